// File: rtl/io_pkg.sv
// io_pkg: register offsets, window size and byte-strobe merge shared by the I/O bridge, CPU decoder and benches
package io_pkg;
  localparam logic [4:0] IO_OFF_OUT0 = 5'h00;
  localparam logic [4:0] IO_OFF_OUT1 = 5'h04;
  localparam logic [4:0] IO_OFF_IN   = 5'h08;
  localparam logic [4:0] IO_OFF_CHG  = 5'h0C;
  localparam logic [4:0] IO_OFF_MASK = 5'h10;
  localparam int IO_WINDOW_BYTES = 20;
  function automatic logic [31:0] io_wmerge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? wd[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/io_sync.sv
// io_sync: two-flop synchronizer for a bus of asynchronous inputs
module io_sync #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two stages per bit to let metastability settle before use
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O responder (OUT0/OUT1/IN/CHG/MASK); IO_BRIDGE_IRQ_EN enables MASK and irq
module io_bridge
  import io_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IO_INPUT_BUS_LEN = 14,
  parameter int IO_OUTPUT_BUS_LEN = 52,
  parameter int IO_BASE_ADDR = 712
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [XLEN-1:0]              addr,
  input  logic [XLEN-1:0]              wdata,
  input  logic [3:0]                   wstrb,
  output logic                         hit,
  output logic                         ack,
  output logic [XLEN-1:0]              rdata,
  input  logic [IO_INPUT_BUS_LEN-1:0]  io_in,
  output logic [IO_OUTPUT_BUS_LEN-1:0] io_out,
  output logic                         irq
);
  localparam int IW = IO_INPUT_BUS_LEN;
  localparam int OW = IO_OUTPUT_BUS_LEN - XLEN;
  localparam logic [XLEN-1:0] BASE = XLEN'(IO_BASE_ADDR);
  logic [XLEN-1:0] off, rd, mask_rd;
  logic [4:0] word;
  logic acc, wr;
  logic [XLEN-1:0] out0;
  logic [OW-1:0] out1;
  logic [IW-1:0] sync, prev, chg, clr;
  assign off = addr - BASE;
  assign hit = (addr >= BASE) && (off < XLEN'(IO_WINDOW_BYTES));
  assign word = {off[4:2], 2'b00};
  assign acc = req & hit;
  assign wr = acc & we;
  assign io_out = {out1, out0};
  assign clr = (wr && word == IO_OFF_CHG) ? IW'(io_wmerge('0, wdata, wstrb)) : '0;
  io_sync #(.W(IW)) u_sync (.clk(clk), .rst(rst), .d(io_in), .q(sync));
  // read mux over the addressed register
  always_comb
    rd = word == IO_OFF_OUT0 ? out0 :
         word == IO_OFF_OUT1 ? XLEN'(out1) :
         word == IO_OFF_IN   ? XLEN'(sync) :
         word == IO_OFF_CHG  ? XLEN'(chg) : mask_rd;
  // response, output registers and sticky change flags (a new change beats a same-cycle clear)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack <= 1'b0;
      rdata <= '0;
      out0 <= '0;
      out1 <= '0;
      prev <= '0;
      chg <= '0;
    end else begin
      ack <= acc;
      rdata <= (acc && !we) ? rd : '0;
      if (wr && word == IO_OFF_OUT0) out0 <= io_wmerge(out0, wdata, wstrb);
      if (wr && word == IO_OFF_OUT1) out1 <= OW'(io_wmerge(XLEN'(out1), wdata, wstrb));
      prev <= sync;
      chg <= (chg & ~clr) | (sync ^ prev);
    end
`ifdef IO_BRIDGE_IRQ_EN
  logic [IW-1:0] mask;
  assign mask_rd = XLEN'(mask);
  // interrupt mask and registered interrupt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && word == IO_OFF_MASK) mask <= IW'(io_wmerge(XLEN'(mask), wdata, wstrb));
      irq <= |(chg & mask);
    end
`else
  assign mask_rd = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge
module tb_io_bridge;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic hit, ack, irq;
  logic [13:0] io_in = 0;
  logic [51:0] io_out;
  int n_chk = 0, n_fail = 0;
  io_bridge dut (.clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
                 .hit(hit), .ack(ack), .rdata(rdata), .io_in(io_in), .io_out(io_out), .irq(irq));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req = 1; we = w; addr = a; wdata = d; wstrb = s;
    edge1();
  endtask
  task automatic idle();
    req = 0; we = 0;
    edge1();
  endtask
  initial begin
    edge1();
    edge1();
    chk("rst_io_out", 64'(io_out), 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_irq", 64'(irq), 0);
    rst = 0;
    idle();
    put(0, 724, 0, 0);
    chk("chg_reset", 64'(rdata), 0);
    put(1, 712, 32'hDEADBEEF, 4'hF);
    chk("st_out0_ack", 64'(ack), 1);
    chk("st_out0_rdata0", 64'(rdata), 0);
    chk("st_out0_io", 64'(io_out[31:0]), 64'hDEADBEEF);
    put(0, 712, 0, 0);
    chk("ld_out0_ack", 64'(ack), 1);
    chk("ld_out0", 64'(rdata), 64'hDEADBEEF);
    idle();
    chk("idle_ack", 64'(ack), 0);
    chk("idle_rdata", 64'(rdata), 0);
    put(1, 712, 32'h00005500, 4'h2);
    put(0, 712, 0, 0);
    chk("b2b_ack", 64'(ack), 1);
    chk("b2b_st_ld", 64'(rdata), 64'hDEAD55EF);
    put(1, 716, 32'hFFFFFFFF, 4'h3);
    chk("st_out1_io", 64'(io_out[51:32]), 64'h0FFFF);
    put(0, 716, 0, 0);
    chk("ld_out1", 64'(rdata), 64'h0000FFFF);
    idle();
    io_in = 14'h2A5;
    edge1();
    chk("in_not_yet", 64'(dut.sync), 0);
    edge1();
    chk("in_2cyc", 64'(dut.sync), 64'h2A5);
    chk("chg_not_yet", 64'(dut.chg), 0);
    edge1();
    chk("chg_3cyc", 64'(dut.chg), 64'h2A5);
    put(0, 720, 0, 0);
    chk("ld_in", 64'(rdata), 64'h2A5);
    put(0, 724, 0, 0);
    chk("ld_chg", 64'(rdata), 64'h2A5);
    put(1, 724, 32'h005, 4'hF);
    put(0, 724, 0, 0);
    chk("chg_w1c", 64'(rdata), 64'h2A0);
    idle();
    io_in = 14'h2A4;
    idle();
    idle();
    put(1, 724, 32'h1, 4'hF);
    put(0, 724, 0, 0);
    chk("chg_set_wins", 64'(rdata), 64'h2A1);
    put(1, 724, 32'h1, 4'hF);
    put(0, 724, 0, 0);
    chk("chg_clear", 64'(rdata), 64'h2A0);
    put(1, 720, 32'hFFFF, 4'hF);
    chk("st_in_ack", 64'(ack), 1);
    put(0, 720, 0, 0);
    chk("st_in_ignored", 64'(rdata), 64'h2A4);
    req = 1; we = 1; addr = 708; wdata = 32'h12345678; wstrb = 4'hF;
    #1;
    chk("hit_708", 64'(hit), 0);
    edge1();
    chk("ack_708", 64'(ack), 0);
    chk("io_708", 64'(io_out), 64'h0FFFF_DEAD55EF);
    addr = 732;
    #1;
    chk("hit_732", 64'(hit), 0);
    edge1();
    chk("ack_732", 64'(ack), 0);
    chk("io_732", 64'(io_out), 64'h0FFFF_DEAD55EF);
    addr = 728;
    #1;
    chk("hit_728", 64'(hit), 1);
    addr = 731; we = 0;
    #1;
    chk("hit_731", 64'(hit), 1);
    addr = 712;
    #1;
    chk("hit_712", 64'(hit), 1);
    put(1, 728, 32'h1, 4'hF);
    chk("st_mask_ack", 64'(ack), 1);
    put(0, 728, 0, 0);
`ifdef IO_BRIDGE_IRQ_EN
    chk("ld_mask", 64'(rdata), 1);
`else
    chk("ld_mask", 64'(rdata), 0);
`endif
    put(1, 724, 32'h3FFF, 4'hF);
    idle();
    idle();
    chk("irq_idle", 64'(irq), 0);
    io_in = 14'h2A5;
    idle();
    idle();
    idle();
    chk("irq_e3", 64'(irq), 0);
    idle();
`ifdef IO_BRIDGE_IRQ_EN
    chk("irq_e4", 64'(irq), 1);
`else
    chk("irq_e4", 64'(irq), 0);
`endif
    put(1, 724, 32'h1, 4'hF);
    idle();
    chk("irq_cleared", 64'(irq), 0);
    put(0, 712, 0, 0);
    chk("pre_rst_ack", 64'(ack), 1);
    rst = 1;
    #1;
    chk("rst_mid_ack", 64'(ack), 0);
    chk("rst_mid_rdata", 64'(rdata), 0);
    chk("rst_mid_io", 64'(io_out), 0);
    edge1();
    chk("rst_no_ack", 64'(ack), 0);
    rst = 0;
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped I/O responder that sits on the CPU data-memory port beside data RAM and services loads and stores whose ALU-computed address falls in the I/O window starting at `IO_BASE_ADDR`. It drives a registered 52-bit output bus (LEDs, 7-segment displays), samples a 14-bit input bus (switches, keys) through a two-flop synchronizer, and records input changes in a sticky status register. The CPU is the initiator; this block is the responder.

## Interface
- `XLEN`, 32: data word width.
- `IO_INPUT_BUS_LEN`, 14: width of external input bus, ≤ XLEN.
- `IO_OUTPUT_BUS_LEN`, 52: width of external output bus, ≤ 2*XLEN.
- `IO_BASE_ADDR`, 712: byte address of first register, word aligned.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request, valid for one cycle.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  XLEN  byte address from ALU.
- `wdata`  in  XLEN  store data.
- `wstrb`  in  4  byte enables for stores.
- `hit`  out  1  combinational: `addr` is inside the window.
- `ack`  out  1  response strobe, one cycle after an accepted request.
- `rdata`  out  XLEN  load data, valid while `ack`=1, else 0.
- `io_in`  in  IO_INPUT_BUS_LEN  asynchronous external inputs.
- `io_out`  out  IO_OUTPUT_BUS_LEN  registered external outputs.
- `irq`  out  1  input-change interrupt (see Configuration).

## Operation
- Window is `IO_BASE_ADDR` to `IO_BASE_ADDR+19`; `addr[1:0]` is ignored for decode. Offsets: 0x0 OUT0 (io_out[31:0]) RW; 0x4 OUT1 (io_out[51:32], bits 31:20 read 0, writes ignored) RW; 0x8 IN (synchronized io_in, zero-extended) RO; 0xC CHG (sticky per-bit change flags) W1C; 0x10 MASK (irq mask) RW.
- Accepted request = `req & hit`. A store updates the selected register on the acceptance edge, honouring `wstrb` per byte. Stores to IN are acked and ignored.
- Loads capture register contents on the acceptance edge into the response register.
- Synchronizer: two flops per bit on `io_in`, then a third `prev` stage. `CHG[i]` is set whenever `sync[i] != prev[i]`.
- CHG set and W1C clear of the same bit in the same cycle: set wins.
- Out-of-window requests: no state change, no `ack`.

## Timing
- Reset values: `io_out`=0, `ack`=0, `rdata`=0, `irq`=0, CHG=0, MASK=0, and synchronizer/`prev` flops=0.
- Latency: `ack` and `rdata` are asserted in cycle N+1 for a request accepted in cycle N, for both loads and stores.
- No backpressure. Back-to-back requests are accepted every cycle, and `ack` stays high across consecutive cycles.
- A store followed immediately by a load of the same register returns the new value.
- `io_out` changes in the cycle after the store edge and is registered, with no combinational path from `wdata`.
- An input edge on `io_in` appears in IN 2 cycles later and sets CHG 3 cycles later.
- If `rst` is asserted during a transaction, the pending `ack` is dropped immediately. Requests are not acked while `rst`=1.

## Configuration
- `IO_BRIDGE_IRQ_EN` defined: `irq` is registered and equals `|(CHG & MASK)`, asserting one cycle after the CHG bit sets. MASK is implemented.
- `IO_BRIDGE_IRQ_EN` undefined: `irq` is tied 0, and MASK is not implemented. Offset 0x10 reads 0, writes to it are ignored but acked, and the window still spans 20 bytes.

## Structure
- Shared package `io_pkg` holds the register offset constants (`IO_OFF_OUT0`, `IO_OFF_OUT1`, `IO_OFF_IN`, `IO_OFF_CHG`, `IO_OFF_MASK`) and `IO_WINDOW_BYTES`=20, so that the CPU address decoder and the benches share them.
- One sub-module, `io_sync`, implements the parameterised-width two-flop synchronizer with async reset.

## Test plan
- Reset, then store 0xDEADBEEF at 712 with `wstrb`=0xF -> `ack` in the next cycle; `io_out[31:0]`=0xDEADBEEF. A load at 712 returns 0xDEADBEEF.
- Store 0xFFFFFFFF at 716 with `wstrb`=0x3 -> `io_out[51:32]`=0x0FFFF. A load at 716 returns 0x0000FFFF.
- Drive `io_in`=0x2A5 -> a load at 720 three or more cycles later returns 0x000002A5, and CHG reads 0x2A5. Store 0x005 to 724 -> CHG reads 0x2A0.
- In the same cycle, toggle `io_in[0]` and store 0x1 to CHG -> CHG[0] remains 1.
- Request at 708 and at 732 -> `hit`=0, no `ack`, no register changes.
- With `IO_BRIDGE_IRQ_EN`: MASK=0x1, toggle `io_in[0]` -> `irq`=1 on cycle 4 after the edge. Clearing CHG -> `irq`=0 next cycle. Assert `rst` mid-load -> `ack`=0 and `io_out`=0 immediately.
